keypad_code_entry: RTL and testbench

- Upstream of the passcode converter / alarm core: turns individual keypad keystrokes into a committed 5-bit passcode.
- Collects up to two decimal digits, then commits on Enter. Abandons the entry on Clear, on a range error, or after an inactivity timeout.
- Presents a held code plus a one-cycle commit strobe to the downstream alarm logic.

---
 rtl/keypad_if.sv | 9 +
 rtl/keypad_code_entry.sv | 163 ++++++++++++++++
 tb/tb_keypad_code_entry.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// Keystroke bus from the keypad scanner into the code-entry logic.
// key_value is meaningful only in cycles where key_valid is high.
interface keypad_if;
  logic       key_valid;
  logic [3:0] key_value;

  modport master (output key_valid, output key_value);
  modport slave  (input  key_valid, input  key_value);
endinterface

// File: rtl/keypad_code_entry.sv
// Keypad digit collector: up to two decimal digits, committed on Enter as a 5-bit code.
// Optional lockout after repeated errors is enabled by defining KEYPAD_LOCKOUT_EN.
module keypad_code_entry #(
  parameter logic [4:0]  IDLE_CODE      = 5'd31,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  keypad_if.slave    kp,
  output logic [4:0] code,
  output logic       code_valid,
  output logic       entry_active,
  output logic       err,
  output logic       locked
);

  // One timer serves both the inactivity timeout and the lockout period.
  localparam int unsigned TMAX1     = (LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TIMER_MAX = (MAX_FAILS > TMAX1) ? MAX_FAILS : TMAX1;
  localparam int unsigned TW        = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_D1,
    S_D2
`ifdef KEYPAD_LOCKOUT_EN
    , S_LOCKED
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      acc_q, acc_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [4:0]      code_d;
  logic            cv_d, err_d, ea_d, done;
  logic            is_digit, is_clear, is_enter;

  assign is_digit = kp.key_valid && (kp.key_value <= 4'd9);
  assign is_clear = kp.key_valid && (kp.key_value == 4'd10);
  assign is_enter = kp.key_valid && (kp.key_value == 4'd11);

`ifdef KEYPAD_LOCKOUT_EN
  localparam int unsigned FW = (MAX_FAILS > 1) ? $clog2(MAX_FAILS + 1) : 1;
  logic [FW-1:0] fails_q, fails_d;
  logic          locked_d;
`endif

  always_comb begin
`ifdef KEYPAD_LOCKOUT_EN
    fails_d  = fails_q;
    locked_d = 1'b0;
`endif
    state_d = state_q;
    acc_d   = acc_q;
    timer_d = '0;
    code_d  = code;
    cv_d    = 1'b0;
    err_d   = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_digit) begin
          acc_d   = {3'b000, kp.key_value};
          state_d = S_D1;
        end
      end
      S_D1, S_D2: begin
        timer_d = kp.key_valid ? '0 : timer_q + TW'(1);
        if (is_digit) begin
          if (state_q == S_D1) begin
            acc_d   = acc_q * 7'd10 + {3'b000, kp.key_value};
            state_d = S_D2;
          end else begin
            err_d = 1'b1;
          end
        end else if (is_enter) begin
          if (acc_q <= 7'd31) begin
            code_d = acc_q[4:0];
            cv_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (is_clear) begin
          done = 1'b1;
        end else if (!kp.key_valid && (timer_q == TW'(TIMEOUT_CYCLES - 1))) begin
          err_d = 1'b1;
        end
      end
`ifdef KEYPAD_LOCKOUT_EN
      S_LOCKED: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (err_d || cv_d || done) begin
      state_d = S_IDLE;
      acc_d   = '0;
      timer_d = '0;
    end

`ifdef KEYPAD_LOCKOUT_EN
    if (cv_d || (is_clear && state_q != S_LOCKED))
      fails_d = '0;
    // The error that reaches the limit still pulses err, then diverts into lockout.
    if (err_d) begin
      if (fails_q == FW'(MAX_FAILS - 1)) begin
        state_d = S_LOCKED;
        fails_d = '0;
        timer_d = '0;
      end else begin
        fails_d = fails_q + FW'(1);
      end
    end
    locked_d = (state_d == S_LOCKED);
`endif

    ea_d = (state_d == S_D1) || (state_d == S_D2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      timer_q      <= '0;
      code         <= IDLE_CODE;
      code_valid   <= 1'b0;
      err          <= 1'b0;
      entry_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      timer_q      <= timer_d;
      code         <= code_d;
      code_valid   <= cv_d;
      err          <= err_d;
      entry_active <= ea_d;
    end
  end

`ifdef KEYPAD_LOCKOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fails_q <= '0;
      locked  <= 1'b0;
    end else begin
      fails_q <= fails_d;
      locked  <= locked_d;
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_code_entry.sv
// Directed self-checking bench for keypad_code_entry (short timeout/lockout for run time).
module tb_keypad_code_entry;

  localparam int unsigned T = 20;
  localparam int unsigned L = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] code;
  logic       code_valid, entry_active, err, locked;
  int         n_cmp = 0;
  int         n_bad = 0;

  keypad_if kif ();

  keypad_code_entry #(
    .IDLE_CODE      (5'd31),
    .TIMEOUT_CYCLES (T),
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (L)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .kp           (kif),
    .code         (code),
    .code_valid   (code_valid),
    .entry_active (entry_active),
    .err          (err),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one key for exactly one rising edge; returns on the following falling edge.
  task automatic press(input logic [3:0] k);
    kif.key_valid = 1'b1;
    kif.key_value = k;
    @(negedge clk);
    kif.key_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    kif.key_valid = 1'b0;
    kif.key_value = 4'd0;
    idle(3);
    chk("rst_code", code, 31);
    chk("rst_cv", code_valid, 0);
    chk("rst_ea", entry_active, 0);
    chk("rst_err", err, 0);
    chk("rst_locked", locked, 0);

    rst_n = 1'b1;
    idle(T + 5);
    chk("idle_code", code, 31);
    chk("idle_cv", code_valid, 0);
    chk("idle_ea", entry_active, 0);
    chk("idle_err", err, 0);

    press(4'd12); press(4'd10); press(4'd11);
    chk("ign_ea", entry_active, 0);
    chk("ign_err", err, 0);
    chk("ign_cv", code_valid, 0);
    chk("ign_code", code, 31);

    press(4'd1);
    chk("a_ea1", entry_active, 1);
    press(4'd9);
    chk("a_ea2", entry_active, 1);
    chk("a_cv0", code_valid, 0);
    press(4'd11);
    chk("a_code", code, 19);
    chk("a_cv", code_valid, 1);
    chk("a_ea", entry_active, 0);
    chk("a_err", err, 0);
    idle(1);
    chk("a_cv_drop", code_valid, 0);
    chk("a_code_hold", code, 19);

    press(4'd4); press(4'd11);
    chk("b_code", code, 4);
    chk("b_cv", code_valid, 1);
    press(4'd4); press(4'd4); press(4'd11);
    chk("b_err", err, 1);
    chk("b_cv0", code_valid, 0);
    chk("b_code_hold", code, 4);
    chk("b_ea", entry_active, 0);
    idle(1);
    chk("b_err_drop", err, 0);

    press(4'd3); press(4'd1); press(4'd11);
    chk("b31_code", code, 31);
    chk("b31_cv", code_valid, 1);
    press(4'd3); press(4'd2); press(4'd11);
    chk("b32_err", err, 1);
    chk("b32_code", code, 31);
    press(4'd0); press(4'd11);
    chk("b0_code", code, 0);
    chk("b0_cv", code_valid, 1);

    press(4'd2);
    idle(T - 1);
    chk("to_pre_err", err, 0);
    chk("to_pre_ea", entry_active, 1);
    idle(1);
    chk("to_err", err, 1);
    chk("to_ea", entry_active, 0);
    chk("to_code", code, 0);
    idle(1);
    chk("to_err_drop", err, 0);

    press(4'd2);
    idle(T - 1);
    press(4'd5);
    chk("exp_err", err, 0);
    chk("exp_ea", entry_active, 1);
    press(4'd11);
    chk("exp_code", code, 25);
    chk("exp_cv", code_valid, 1);

    press(4'd6);
    idle(T - 1);
    press(4'd13);
    chk("k13_err", err, 0);
    chk("k13_ea", entry_active, 1);
    idle(T - 1);
    chk("k13_pre_err", err, 0);
    idle(1);
    chk("k13_to_err", err, 1);
    chk("k13_code", code, 25);

    press(4'd7); press(4'd10);
    chk("clr_ea", entry_active, 0);
    chk("clr_err", err, 0);
    press(4'd11);
    chk("clr_ent_cv", code_valid, 0);
    chk("clr_ent_err", err, 0);
    chk("clr_code", code, 25);
    press(4'd3); press(4'd1);
    chk("d3_ea", entry_active, 1);
    press(4'd5);
    chk("d3_err", err, 1);
    chk("d3_ea0", entry_active, 0);
    chk("d3_cv", code_valid, 0);
    chk("d3_code", code, 25);

    press(4'd1);
    chk("mr_ea1", entry_active, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_ea", entry_active, 0);
    chk("mr_code", code, 31);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("mr_code_post", code, 31);

`ifdef KEYPAD_LOCKOUT_EN
    press(4'd9); press(4'd9); press(4'd11);
    chk("lk_err1", err, 1);
    chk("lk_lock1", locked, 0);
    press(4'd9); press(4'd9); press(4'd11);
    chk("lk_err2", err, 1);
    chk("lk_lock2", locked, 0);
    press(4'd9); press(4'd9); press(4'd11);
    chk("lk_err3", err, 1);
    chk("lk_lock3", locked, 1);
    chk("lk_ea3", entry_active, 0);
    press(4'd1); press(4'd11);
    chk("lk_ign_lock", locked, 1);
    chk("lk_ign_cv", code_valid, 0);
    chk("lk_ign_ea", entry_active, 0);
    chk("lk_ign_code", code, 31);
    idle(L - 3);
    chk("lk_still", locked, 1);
    idle(1);
    chk("lk_release", locked, 0);
    chk("lk_rel_err", err, 0);
    press(4'd1); press(4'd11);
    chk("lk_code", code, 1);
    chk("lk_cv", code_valid, 1);
`else
    press(4'd9); press(4'd9); press(4'd11);
    press(4'd9); press(4'd9); press(4'd11);
    press(4'd9); press(4'd9); press(4'd11);
    chk("nolk_err3", err, 1);
    chk("nolk_lock", locked, 0);
    press(4'd1); press(4'd11);
    chk("nolk_code", code, 1);
    chk("nolk_cv", code_valid, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
